fetch_unit: RTL and testbench

Instruction fetch stage of the MIPS32 single-cycle core. It sits directly upstream of the control unit: it holds the PC, fetches words from a variable-latency instruction memory, and presents the current instruction, whose opcode field drives the control unit. It also consumes the control unit's branch/bne/jump decisions and the ALU zero flag at retire to compute the next PC.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/next_pc_calc.sv | 39 +++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 single-cycle core: reset PC, opcodes, fetch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection for the held instruction: sequential, branch target or jump target.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to consume next_pc.
module next_pc_calc (
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        bne,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] imm_sx;
  logic [31:0] btgt;
  logic [31:0] jtgt;
  logic        taken;
  logic        unused_opcode;

  // The opcode bits play no part in target arithmetic; decode lives in the control unit.
  assign unused_opcode = ^instr[31:26];

  // Targets wrap mod 2^32; jump has priority over any branch condition.
  always_comb begin
    pc_plus4 = pc + 32'd4;
    imm_sx   = {{16{instr[15]}}, instr[15:0]};
    btgt     = pc_plus4 + {imm_sx[29:0], 2'b00};
    jtgt     = {pc_plus4[31:28], instr[25:0], 2'b00};
    taken    = (branch & zero) | (bne & ~zero);
    next_pc  = pc_plus4;
    if (jump) begin
      next_pc = jtgt;
    end else if (taken) begin
      next_pc = btgt;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: holds PC, fetches from variable-latency imem, presents instr until retired.
// Latency: instr_valid one cycle after the imem_valid edge; at best one instruction per 2 cycles.
// Backpressure: instr/pc/instret held while instr_valid=1 and instr_ready=0; imem_req held until imem_valid.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        bne,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] instret
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         instr_valid_q, instr_valid_d;
  logic         imem_req_q, imem_req_d;
  logic [31:0]  instret_q, instret_d;
  logic [31:0]  next_pc;

  next_pc_calc u_next_pc (
    .pc       (pc_q),
    .instr    (instr_q),
    .branch   (branch),
    .bne      (bne),
    .jump     (jump),
    .zero     (zero),
    .next_pc  (next_pc),
    .pc_plus4 (pc_plus4)
  );

  // FSM next-state: BOOT idles one cycle, FETCH waits on memory, HOLD waits on retire.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    imem_req_d    = imem_req_q;
    instret_d     = instret_q;
    case (state_q)
      BOOT: begin
        state_d    = FETCH;
        imem_req_d = 1'b1;
      end
      FETCH: begin
        if (imem_valid) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
          state_d       = HOLD;
        end else begin
          imem_req_d = 1'b1;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          pc_d          = next_pc;
          instret_d     = instret_q + 32'd1;
          instr_valid_d = 1'b0;
          imem_req_d    = 1'b1;
          state_d       = FETCH;
        end
      end
      default: begin
        state_d    = BOOT;
        imem_req_d = 1'b0;
      end
    endcase
  end

  // All fetch state and registered outputs; reset aborts any fetch in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      instret_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      instret_q     <= instret_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of presented instructions.
// Latency: memory model answers after a per-vector number of cycles.
// Backpressure: retire is driven explicitly per vector.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_valid = 1'b0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch = 1'b0;
  logic        bne = 1'b0;
  logic        jump = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] instret;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] instret;
  } exp_t;

  exp_t sb_q[$];
  logic seen = 1'b0;

  fetch_unit #(.RESET_PC(32'h0040_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .branch      (branch),
    .bne         (bne),
    .jump        (jump),
    .zero        (zero),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each new presentation of instr_valid pops one expected entry.
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (instr_valid && !seen) begin
      seen = 1'b1;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_instr", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("mon_pc", pc, e.pc);
        check("mon_instr", instr, e.instr);
        check("mon_opcode", {26'd0, opcode}, {26'd0, e.instr[31:26]});
        check("mon_pc_plus4", pc_plus4, e.pc + 32'd4);
        check("mon_instret", instret, e.instret);
      end
    end else if (!instr_valid) begin
      seen = 1'b0;
    end
  end

  // Memory model for one fetch; expected presentation is queued before answering.
  task automatic do_fetch(input logic [31:0] word, input int lat,
                          input logic [31:0] exp_pc, input logic [31:0] exp_ret);
    int n;
    exp_t e;
    n = 0;
    e.pc = exp_pc;
    e.instr = word;
    e.instret = exp_ret;
    sb_q.push_back(e);
    while (!imem_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, exp_pc);
    repeat (lat) begin
      @(posedge clk); #1;
    end
    imem_valid = 1'b1;
    imem_rdata = word;
    @(posedge clk); #1;
    imem_valid = 1'b0;
    imem_rdata = 32'd0;
  endtask

  task automatic do_retire(input logic br, input logic bn, input logic jp, input logic z);
    check("retire_valid", {31'd0, instr_valid}, 32'd1);
    branch = br;
    bne = bn;
    jump = jp;
    zero = z;
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    branch = 1'b0;
    bne = 1'b0;
    jump = 1'b0;
    zero = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_addr"}, imem_addr, 32'h0040_0000);
    check({tag, "_pc"}, pc, 32'h0040_0000);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_instret"}, instret, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state while rst is held
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b0;
    @(negedge clk);
    check("boot_req_low", {31'd0, imem_req}, 32'd0);

    // I0: addiu, 2-cycle memory, then backpressure with spurious imem_valid
    do_fetch(32'h2408_0001, 2, 32'h0040_0000, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      imem_valid = (i == 2);
      imem_rdata = (i == 2) ? 32'hDEAD_BEEF : 32'd0;
    end
    imem_valid = 1'b0;
    imem_rdata = 32'd0;
    check("hold_instr", instr, 32'h2408_0001);
    check("hold_pc", pc, 32'h0040_0000);
    check("hold_instret", instret, 32'd0);
    check("hold_valid", {31'd0, instr_valid}, 32'd1);
    check("hold_req", {31'd0, imem_req}, 32'd0);
    do_retire(0, 0, 0, 0);

    // I1: j to 0x00400010, zero-latency memory
    do_fetch(32'h0810_0004, 0, 32'h0040_0004, 32'd1);
    do_retire(0, 0, 1, 0);
    // I2: beq imm=-4 taken -> 0x00400004
    do_fetch(32'h1000_FFFC, 1, 32'h0040_0010, 32'd2);
    do_retire(1, 0, 0, 1);
    // I3: j back to 0x00400010
    do_fetch(32'h0810_0004, 0, 32'h0040_0004, 32'd3);
    do_retire(0, 0, 1, 0);
    // I4: beq not taken -> 0x00400014
    do_fetch(32'h1000_FFFC, 3, 32'h0040_0010, 32'd4);
    do_retire(1, 0, 0, 0);
    // I5: bne imm=3 taken -> pc+16 = 0x00400024
    do_fetch(32'h1400_0003, 0, 32'h0040_0014, 32'd5);
    do_retire(0, 1, 0, 0);
    // I6: branch and bne both set, zero=0 -> bne term taken -> 0x00400034
    do_fetch(32'h1400_0003, 1, 32'h0040_0024, 32'd6);
    do_retire(1, 1, 0, 0);
    // I7: j to 0x00400000
    do_fetch(32'h0810_0000, 0, 32'h0040_0034, 32'd7);
    do_retire(0, 0, 1, 0);
    // I8: jump and branch together, jump wins -> 0x0040000C
    do_fetch(32'h0810_0003, 2, 32'h0040_0000, 32'd8);
    do_retire(1, 0, 1, 1);
    // I9: j to 0x00000000
    do_fetch(32'h0800_0000, 0, 32'h0040_000C, 32'd9);
    do_retire(0, 0, 1, 0);
    // I10: beq imm=-2 at pc 0 -> 0xFFFFFFFC
    do_fetch(32'h1000_FFFE, 1, 32'h0000_0000, 32'd10);
    do_retire(1, 0, 0, 1);
    // I11: at 0xFFFFFFFC; preset instret to all-ones, sequential retire wraps both
    do_fetch(32'h2408_0001, 0, 32'hFFFF_FFFC, 32'd11);
    @(negedge clk); #1;
    force dut.instret_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.instret_q;
    do_retire(0, 0, 0, 0);
    check("wrap_instret", instret, 32'd0);
    check("wrap_pc", pc, 32'd0);

    // I12: sequential wrap landed at 0; then async reset mid-HOLD
    do_fetch(32'h8C09_0000, 1, 32'h0000_0000, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_hold");
    @(posedge clk); #1;
    rst = 1'b0;

    // Async reset mid-FETCH with no memory response
    n = 0;
    while (!imem_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_fetch_req", {31'd0, imem_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_fetch");

    // Spurious imem_valid during BOOT is ignored
    @(posedge clk); #1;
    rst = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    imem_valid = 1'b0;
    imem_rdata = 32'd0;
    check("boot_spurious_valid", {31'd0, instr_valid}, 32'd0);
    check("boot_spurious_instr", instr, 32'd0);

    // I13: lui after reset
    do_fetch(32'h3C01_1234, 2, 32'h0040_0000, 32'd0);
    do_retire(0, 0, 0, 0);
    check("final_pc", pc, 32'h0040_0004);
    check("final_instret", instret, 32'd1);

    repeat (3) @(posedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
